// File: rtl/round_controller.sv
// Reaction-game round sequencer: arms the timer, lights a pseudo-random target and judges hits.
// Optional HIGH_SCORE_EN keeps a best-score register that survives between games.
module round_controller #(
   parameter int NUM_TARGETS = 4,
   parameter int START_LIVES = 3,
   parameter int WINDOW_MS   = 1000,
   parameter int GAP_CYCLES  = 25000,
   parameter int SCORE_W     = 10
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [1:0]             i_difficulty_sel,
   input  logic [NUM_TARGETS-1:0] i_hit,
   input  logic                   i_end_reached,
   input  logic [11:0]            i_timer_value,
   output logic                   o_timer_reset,
   output logic                   o_timer_enable,
   output logic [1:0]             o_difficulty,
   output logic [11:0]            o_end_value,
   output logic [NUM_TARGETS-1:0] o_target,
   output logic [SCORE_W-1:0]     o_score,
   output logic [1:0]             o_lives,
   output logic [11:0]            o_reaction_ms,
   output logic                   o_game_over,
   output logic [SCORE_W-1:0]     o_best_score,
   output logic [2:0]             o_dbg_state
);

   localparam int IDX_W    = $clog2(NUM_TARGETS);
   localparam int GAP_W    = $clog2(GAP_CYCLES + 1);
   // The ARM cycle is also blank, so GAP itself lasts GAP_CYCLES-1 cycles (minimum 1).
   localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_PLAY = 3'd2,
      S_GAP  = 3'd3,
      S_OVER = 3'd4
   } state_t;

   state_t                 r_state;
   logic [7:0]             r_lfsr;
   logic [GAP_W-1:0]       r_gap_cnt;
   logic [NUM_TARGETS-1:0] r_target;
   logic [NUM_TARGETS-1:0] r_last_target;
   logic [SCORE_W-1:0]     r_score;
   logic [1:0]             r_lives;
   logic [1:0]             r_difficulty;
   logic [11:0]            r_reaction_ms;
   logic                   r_timer_reset;
   logic                   r_timer_enable;
   logic                   r_game_over;

   logic                   w_lfsr_fb;
   logic [NUM_TARGETS-1:0] w_pick;
   logic [NUM_TARGETS-1:0] w_rot;
   logic [NUM_TARGETS-1:0] w_next_target;
   logic                   w_correct;
   logic                   w_wrong;
   logic [SCORE_W-1:0]     w_score_inc;

   assign w_lfsr_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_pick        = {{(NUM_TARGETS-1){1'b0}}, 1'b1} << r_lfsr[IDX_W-1:0];
   assign w_rot         = {w_pick[NUM_TARGETS-2:0], w_pick[NUM_TARGETS-1]};
   assign w_next_target = (w_pick == r_last_target) ? w_rot : w_pick;
   assign w_correct     = (i_hit == r_target);
   assign w_wrong       = |(i_hit & ~r_target);
   assign w_score_inc   = (&r_score) ? r_score : r_score + 1'b1;

`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0] r_best_score;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= S_IDLE;
         r_lfsr         <= 8'h01;
         r_gap_cnt      <= '0;
         r_target       <= '0;
         r_last_target  <= '0;
         r_score        <= '0;
         r_lives        <= '0;
         r_difficulty   <= '0;
         r_reaction_ms  <= '0;
         r_timer_reset  <= 1'b1;
         r_timer_enable <= 1'b0;
         r_game_over    <= 1'b0;
`ifdef HIGH_SCORE_EN
         r_best_score   <= '0;
`endif
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
         case (r_state)
            S_IDLE, S_OVER: begin
               if (i_start) begin
                  r_state        <= S_ARM;
                  r_score        <= '0;
                  r_lives        <= 2'(START_LIVES);
                  r_difficulty   <= i_difficulty_sel;
                  r_timer_reset  <= 1'b1;
                  r_timer_enable <= 1'b1;
                  r_game_over    <= 1'b0;
               end
            end
            S_ARM: begin
               r_state        <= S_PLAY;
               r_target       <= w_next_target;
               r_last_target  <= w_next_target;
               r_timer_reset  <= 1'b0;
               r_timer_enable <= 1'b1;
            end
            S_PLAY: begin
               // A clean hit wins over a simultaneous window expiry.
               if (w_correct || w_wrong || i_end_reached) begin
                  r_state        <= S_GAP;
                  r_gap_cnt      <= '0;
                  r_target       <= '0;
                  r_timer_enable <= 1'b0;
                  if (w_correct) begin
                     r_score       <= w_score_inc;
                     r_reaction_ms <= i_timer_value;
                  end else if (r_lives != 2'd0) begin
                     r_lives <= r_lives - 2'd1;
                  end
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
                  if (r_lives == 2'd0) begin
                     r_state        <= S_OVER;
                     r_game_over    <= 1'b1;
                     r_timer_reset  <= 1'b1;
`ifdef HIGH_SCORE_EN
                     if (r_score > r_best_score) r_best_score <= r_score;
`endif
                  end else begin
                     r_state        <= S_ARM;
                     r_timer_reset  <= 1'b1;
                     r_timer_enable <= 1'b1;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_timer_reset  = r_timer_reset;
   assign o_timer_enable = r_timer_enable;
   assign o_difficulty   = r_difficulty;
   assign o_end_value    = 12'(WINDOW_MS);
   assign o_target       = r_target;
   assign o_score        = r_score;
   assign o_lives        = r_lives;
   assign o_reaction_ms  = r_reaction_ms;
   assign o_game_over    = r_game_over;
   assign o_dbg_state    = r_state;
`ifdef HIGH_SCORE_EN
   assign o_best_score   = r_best_score;
`else
   assign o_best_score   = '0;
`endif

endmodule
